// File: rtl/dmem_responder.sv
// Single-port data memory that answers a core's data-memory request port.
// Byte/half/word lanes from funct3, one-cycle ready after LATENCY cycles.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_DM_Addr,
  input  logic [31:0] i_DM_Wd,
  input  logic [2:0]  i_DM_f3,
  input  logic        i_DM_Wen,
  input  logic        i_DM_MemRead,
  output logic        o_DM_data_ready,
  output logic [31:0] o_DM_ReadData,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  f3_q, f3_d;
  logic        wen_q, wen_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        access;
  logic [31:0] a_addr, a_wd;
  logic [2:0]  a_f3;
  logic        a_wen;
  logic [31:0] off;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        is_b, is_h, uns, illegal, mis;
  logic [31:0] old, ext, wdat;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  be;
  logic        we;

  assign req = i_DM_Wen | i_DM_MemRead;

  // Access operands: live inputs when accessing straight from IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      a_addr = i_DM_Addr;
      a_wd   = i_DM_Wd;
      a_f3   = i_DM_f3;
      a_wen  = i_DM_Wen;
    end else begin
      a_addr = addr_q;
      a_wd   = wd_q;
      a_f3   = f3_q;
      a_wen  = wen_q;
    end
  end

  assign off      = a_addr - BASE_ADDR;
  assign lane     = off[1:0];
  assign idx      = off[AW+1:2];
  assign in_range = (a_addr >= BASE_ADDR) && (off[31:AW+2] == '0);
  assign is_b     = (a_f3[1:0] == 2'b00);
  assign is_h     = (a_f3[1:0] == 2'b01);
  assign uns      = a_f3[2];
  assign illegal  = (a_f3 == 3'b110) || (a_f3[1:0] == 2'b11);
  assign old      = mem[idx];
  assign bsel     = old[{lane, 3'b000} +: 8];
  assign hsel     = lane[1] ? old[31:16] : old[15:0];

  // Lane decode: misaligned accesses fall back to the aligned-down lanes.
  always_comb begin
    unique case (1'b1)
      is_b: begin
        be   = 4'b0001 << lane;
        wdat = {4{a_wd[7:0]}};
        ext  = {{24{~uns & bsel[7]}}, bsel};
        mis  = 1'b0;
      end
      is_h: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{a_wd[15:0]}};
        ext  = {{16{~uns & hsel[15]}}, hsel};
        mis  = lane[0];
      end
      default: begin
        be   = 4'b1111;
        wdat = a_wd;
        ext  = old;
        mis  = (lane != 2'b00);
      end
    endcase
  end

  assign we = access & a_wen & in_range & ~i_rst;

  // Next-state logic: capture, latency countdown, single ready cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    wen_d   = wen_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = i_DM_Addr;
          wd_d   = i_DM_Wd;
          f3_d   = i_DM_f3;
          wen_d  = i_DM_Wen;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (access) begin
      ready_d = 1'b1;
      err_d   = ~in_range | mis | illegal;
      rdata_d = in_range ? ext : 32'h0;
    end
  end

  // State and response registers; reset also kills a pending ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      wen_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      wen_q   <= wen_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-enabled store; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];
      end
    end
  end

  assign o_DM_data_ready = ready_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_err           = err_q;

endmodule
